// File: rtl/iddmm_loader_pkg.sv
// Shared types and encodings for the IDDMM operand loader: FSM states, word tags
// and RAM write-enable bit positions.
package iddmm_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_X  = 2'd0;
  localparam logic [1:0] SEL_Y  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_M1 = 2'd3;

  localparam int WR_X = 0;
  localparam int WR_Y = 1;
  localparam int WR_M = 2;

  // The m1 tag has no RAM behind it, so it maps to an all-zero enable.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = '0;
    case (sel)
      SEL_X:   oh[WR_X] = 1'b1;
      SEL_Y:   oh[WR_Y] = 1'b1;
      SEL_M:   oh[WR_M] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/iddmm_loader_if.sv
// Bundle of the loader's word stream, multiplier RAM write port and task handshake.
// master = loader side, slave = environment (stream source + multiplier) side.
interface iddmm_loader_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
);

  logic              s_valid;
  logic              s_ready;
  logic [1:0]        s_sel;
  logic [K-1:0]      s_data;

  logic [2:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;

  logic              task_req;
  logic              task_grant;
  logic              task_end;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  s_valid, s_sel, s_data, task_grant, task_end,
    output s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
    output task_req, busy, done, err
  );

  modport slave (
    output s_valid, s_sel, s_data, task_grant, task_end,
    input  s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
    input  task_req, busy, done, err
  );

endinterface

// File: rtl/iddmm_loader_word_cnt.sv
// Per-operand RAM address counter; counts 0..N inclusive and flags when N words
// have been written.
module iddmm_word_cnt
  import iddmm_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_VAL = (ADDR_W + 1)'(N);

  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != FULL_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr = cnt_q[ADDR_W-1:0];
  assign full = (cnt_q == FULL_VAL);

endmodule

// File: rtl/iddmm_loader.sv
// Converts a tagged K-bit word stream into IDDMM RAM writes, then runs the task handshake.
// Optional: IDDMM_LOADER_REUSE_M_EN keeps m and m1 loaded across tasks.
module iddmm_loader
  import iddmm_pkg::*;
#(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  iddmm_loader_if.master  bus
);

`ifdef IDDMM_LOADER_REUSE_M_EN
  localparam bit REUSE_M = 1'b1;
`else
  localparam bit REUSE_M = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [K-1:0]      m1_q, m1_d;
  logic              m1_ok_q, m1_ok_d;
  logic              err_q, err_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_x_q, wr_x_d;
  logic [K-1:0]      wr_y_q, wr_y_d;
  logic [K-1:0]      wr_m_q, wr_m_d;
  logic              s_ready_q, s_ready_d;
  logic              task_req_q, task_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] addr [3];
  logic [2:0]        full;
  logic [2:0]        inc;
  logic [2:0]        clr;
  logic              xfer;
  logic              sel_full;
  logic [ADDR_W-1:0] sel_addr;

  assign xfer = bus.s_valid & s_ready_q;
  assign inc  = wr_ena_d;

  // With reuse enabled, the m counter survives DONE so only x and y need reloading.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    assign clr[gi] = (state_q == DONE) && !(REUSE_M && (gi == WR_M));

    iddmm_word_cnt #(
      .N      (N),
      .ADDR_W (ADDR_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr[gi]),
      .inc   (inc[gi]),
      .addr  (addr[gi]),
      .full  (full[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    m1_d      = m1_q;
    m1_ok_d   = m1_ok_q;
    err_d     = err_q;
    wr_ena_d  = '0;
    wr_addr_d = wr_addr_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_m_d    = wr_m_q;
    sel_full  = 1'b0;
    sel_addr  = '0;

    case (bus.s_sel)
      SEL_X:   begin sel_full = full[WR_X]; sel_addr = addr[WR_X]; end
      SEL_Y:   begin sel_full = full[WR_Y]; sel_addr = addr[WR_Y]; end
      SEL_M:   begin sel_full = full[WR_M]; sel_addr = addr[WR_M]; end
      default: ;
    endcase

    // m1 must arrive first because the multiplier latches wr_m1 on any RAM write.
    if (xfer) begin
      if (bus.s_sel == SEL_M1) begin
        m1_d    = bus.s_data;
        m1_ok_d = 1'b1;
      end else if (!m1_ok_q || sel_full) begin
        err_d = 1'b1;
      end else begin
        wr_ena_d  = sel_onehot(bus.s_sel);
        wr_addr_d = sel_addr;
        case (bus.s_sel)
          SEL_X:   wr_x_d = bus.s_data;
          SEL_Y:   wr_y_d = bus.s_data;
          default: wr_m_d = bus.s_data;
        endcase
      end
    end

    case (state_q)
      LOAD: if ((&full) && m1_ok_q) state_d = REQ;
      REQ:  if (bus.task_grant) state_d = bus.task_end ? DONE : RUN;
      RUN:  if (bus.task_end) state_d = DONE;
      DONE: begin
        state_d = LOAD;
        if (!REUSE_M) m1_ok_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase

    s_ready_d  = (state_d == LOAD);
    task_req_d = (state_d == REQ);
    busy_d     = (state_d == REQ) || (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      m1_q       <= '0;
      m1_ok_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_ena_q   <= '0;
      wr_addr_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_m_q     <= '0;
      s_ready_q  <= 1'b0;
      task_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m1_q       <= m1_d;
      m1_ok_q    <= m1_ok_d;
      err_q      <= err_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_m_q     <= wr_m_d;
      s_ready_q  <= s_ready_d;
      task_req_q <= task_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.wr_ena   = wr_ena_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_x     = wr_x_q;
  assign bus.wr_y     = wr_y_q;
  assign bus.wr_m     = wr_m_q;
  assign bus.wr_m1    = m1_q;
  assign bus.task_req = task_req_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
